// File: rtl/dma_pkg.sv
// dma_pkg: shared AHB transfer encodings and arbiter FSM states for the DMA master port
package dma_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  typedef enum logic {ST_IDLE, ST_OWN} state_t;
  function automatic logic is_active(input logic [1:0] t);
    return t == HTRANS_NONSEQ || t == HTRANS_SEQ;
  endfunction
endpackage

// File: rtl/dma_master_arb_mux_if.sv
// dma_master_arb_mux_if: per-channel request/bus bundle and muxed AHB master signals
interface dma_master_arb_mux_if #(
  parameter int NUM_CH = 6,
  parameter int AW = 32,
  parameter int DW = 32
);
  localparam int CHW = $clog2(NUM_CH);
  logic [NUM_CH-1:0] ch_req, ch_last, ch_hwrite, ch_gnt, ch_done;
  logic [NUM_CH*AW-1:0] ch_haddr;
  logic [NUM_CH*2-1:0] ch_htrans;
  logic [NUM_CH*DW-1:0] ch_hwdata;
  logic hready, hwrite;
  logic [AW-1:0] haddr;
  logic [1:0] htrans;
  logic [DW-1:0] hwdata;
  logic [CHW-1:0] DMACActivedChannel, data_ch;
  modport master (
    input ch_req, ch_last, ch_haddr, ch_htrans, ch_hwrite, ch_hwdata, hready,
    output haddr, htrans, hwrite, hwdata, ch_gnt, ch_done, DMACActivedChannel, data_ch
  );
  modport slave (
    output ch_req, ch_last, ch_haddr, ch_htrans, ch_hwrite, ch_hwdata, hready,
    input haddr, htrans, hwrite, hwdata, ch_gnt, ch_done, DMACActivedChannel, data_ch
  );
endinterface

// File: rtl/dma_rr_arbiter.sv
// dma_rr_arbiter: rotate-priority encoder, search starts at ptr+1 and ptr itself is served last
module dma_rr_arbiter #(
  parameter int N = 6,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         any
);
  int j;
  assign any = |req;
  // scan from lowest priority to highest so the closest requester after ptr overwrites the rest
  always_comb begin
    gnt = '0;
    idx = '0;
    j = 0;
    for (int k = N; k >= 1; k--) begin
      j = (int'(ptr) + k) % N;
      if (req[j]) begin
        gnt = '0;
        gnt[j] = 1'b1;
        idx = W'(j);
      end
    end
  end
endmodule

// File: rtl/dma_master_arb_mux.sv
// dma_master_arb_mux: round-robin AHB address-phase arbiter with one-stage data-phase channel tracking
module dma_master_arb_mux
  import dma_pkg::*;
#(
  parameter int NUM_CH = 6,
  parameter int AW = 32,
  parameter int DW = 32
) (
  input logic hclk,
  input logic hreset,
  dma_master_arb_mux_if.master bus
);
  localparam int CHW = $clog2(NUM_CH);
  state_t state, state_n;
  logic [CHW-1:0] owner, owner_n, rr_ptr, rr_ptr_n, win_idx, dch;
  logic [NUM_CH-1:0] win_gnt, gnt_q, gnt_n;
  logic any, d_valid, own_active, release_own;
  logic [1:0] own_htrans;

  dma_rr_arbiter #(.N(NUM_CH), .W(CHW)) u_arb (
    .req(bus.ch_req), .ptr(rr_ptr), .gnt(win_gnt), .idx(win_idx), .any(any)
  );

  assign own_htrans  = bus.ch_htrans[int'(owner)*2 +: 2];
  assign own_active  = state == ST_OWN && is_active(own_htrans);
  assign release_own = state == ST_OWN && ((bus.ch_last[owner] && is_active(own_htrans)) || !bus.ch_req[owner]);

  always_comb begin
    state_n = state;
    owner_n = owner;
    rr_ptr_n = rr_ptr;
    gnt_n = gnt_q;
    if (bus.hready && (state == ST_IDLE || release_own)) begin
      state_n = any ? ST_OWN : ST_IDLE;
      owner_n = any ? win_idx : owner;
      rr_ptr_n = any ? win_idx : rr_ptr;
      gnt_n = win_gnt;
    end
  end

  always_ff @(posedge hclk)
    if (hreset) begin
      state <= ST_IDLE;
      owner <= '0;
      rr_ptr <= CHW'(NUM_CH - 1);
      gnt_q <= '0;
      d_valid <= 1'b0;
      dch <= '0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      rr_ptr <= rr_ptr_n;
      gnt_q <= gnt_n;
      if (bus.hready) begin
        d_valid <= own_active;
        dch <= owner;
      end
    end

  assign bus.haddr = state == ST_OWN ? bus.ch_haddr[int'(owner)*AW +: AW] : '0;
  assign bus.htrans = state == ST_OWN ? own_htrans : HTRANS_IDLE;
  assign bus.hwrite = state == ST_OWN && bus.ch_hwrite[owner];
  assign bus.hwdata = bus.ch_hwdata[int'(dch)*DW +: DW];
  // a data phase caught by reset is abandoned, so completion is masked while reset is asserted
  assign bus.ch_done = (bus.hready && d_valid && !hreset) ? NUM_CH'(1) << dch : '0;
  assign bus.ch_gnt = gnt_q;
  assign bus.DMACActivedChannel = owner;
  assign bus.data_ch = dch;
endmodule

// File: tb/tb_dma_master_arb_mux.sv
// tb_dma_master_arb_mux: channel-engine stimulus with grant/completion scoreboards on a 6- and a 3-channel instance
module tb_dma_master_arb_mux;
  import dma_pkg::*;
  logic hclk = 1'b0, hreset = 1'b1;
  always #5 hclk = ~hclk;

  dma_master_arb_mux_if #(.NUM_CH(6), .AW(32), .DW(32)) a();
  dma_master_arb_mux_if #(.NUM_CH(3), .AW(32), .DW(64)) b();
  dma_master_arb_mux #(.NUM_CH(6), .AW(32), .DW(32)) dut_a (.hclk(hclk), .hreset(hreset), .bus(a));
  dma_master_arb_mux #(.NUM_CH(3), .AW(32), .DW(64)) dut_b (.hclk(hclk), .hreset(hreset), .bus(b));

  typedef struct {int ch; logic [63:0] data;} exp_t;
  exp_t dq[$], bdq[$];
  int gq[$], bgq[$];
  int errors = 0, checks = 0;
  int want[6], nbeats[6], bursts[6], drop_after[6], sent[6];
  logic [31:0] hw[6];
  int tag = 0, stall_cnt = 0, gaps = 0;
  bit stall_arm = 0, seen_grant = 0;
  logic [5:0] acc_s = '0;
  logic [5:0] prev_gnt = '0;
  logic [2:0] bprev = '0;
  logic prev_hready = 1'b1;
  logic [31:0] prev_haddr = '0, prev_hwdata = '0;
  logic [2:0] prev_dch = '0;

  function automatic logic [31:0] base(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h100;
  endfunction

  function automatic logic [63:0] bdata(input int i);
    return 64'hA5A5_0000_0000_0000 | (64'(i + 1) << 40) | (64'(i + 1) * 64'h1111);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 6; i++) begin
      bit on;
      on = want[i] != 0 && bursts[i] > 0;
      a.ch_req[i] = on;
      a.ch_htrans[i*2 +: 2] = on ? (sent[i] == 0 ? HTRANS_NONSEQ : HTRANS_SEQ) : HTRANS_IDLE;
      a.ch_last[i] = sent[i] == nbeats[i] - 1;
      a.ch_haddr[i*32 +: 32] = base(i) + 32'(sent[i]) * 4;
      a.ch_hwrite[i] = 1'b1;
      a.ch_hwdata[i*32 +: 32] = hw[i];
    end
    if (stall_cnt > 0) begin
      a.hready = 1'b0;
      stall_cnt--;
    end else a.hready = 1'b1;
  endtask

  task automatic update();
    for (int i = 0; i < 6; i++)
      if (acc_s[i]) begin
        tag++;
        hw[i] = 32'hD000_0000 | (32'(i) << 16) | 32'(tag);
        dq.push_back('{ch: i, data: 64'(hw[i])});
        sent[i]++;
        if (sent[i] == drop_after[i]) want[i] = 0;
        if (sent[i] == nbeats[i]) begin
          sent[i] = 0;
          bursts[i]--;
        end
      end
    if (stall_arm && sent[2] == 1 && a.ch_gnt[2]) begin
      stall_arm = 0;
      stall_cnt = 3;
    end
  endtask

  task automatic cyc();
    @(posedge hclk);
    #1;
    update();
    drive();
  endtask

  task automatic eng_reset();
    for (int i = 0; i < 6; i++) begin
      want[i] = 0; nbeats[i] = 1; bursts[i] = 0; drop_after[i] = -1; sent[i] = 0;
      hw[i] = 32'hFEED_0000 | 32'(i);
    end
    stall_cnt = 0;
    stall_arm = 0;
    drive();
  endtask

  task automatic setch(input int i, input int nb, input int bu);
    want[i] = 1; nbeats[i] = nb; bursts[i] = bu;
  endtask

  task automatic chk_reset_vals();
    @(negedge hclk);
    chk("rst_htrans", a.htrans, HTRANS_IDLE);
    chk("rst_gnt", a.ch_gnt, 0);
    chk("rst_done", a.ch_done, 0);
    chk("rst_owner", a.DMACActivedChannel, 0);
    chk("rst_data_ch", a.data_ch, 0);
    chk("rst_haddr", a.haddr, 0);
    chk("rst_hwrite", a.hwrite, 0);
    chk("rst_hwdata", a.hwdata, 32'hFEED_0000);
  endtask

  task automatic do_reset();
    hreset = 1'b1;
    eng_reset();
    dq.delete();
    gq.delete();
    cyc();
    cyc();
    chk_reset_vals();
    hreset = 1'b0;
    seen_grant = 0;
    gaps = 0;
  endtask

  task automatic drain(input string nm);
    chk({nm, "_done_left"}, dq.size(), 0);
    chk({nm, "_grant_left"}, gq.size(), 0);
  endtask

  always @(negedge hclk) begin
    exp_t e;
    int g;
    for (int i = 0; i < 6; i++) acc_s[i] = a.hready && !hreset && a.ch_gnt[i] && a.ch_htrans[i*2+1];
    if (a.ch_done != 0) begin
      if (dq.size() == 0) begin
        checks++; errors++;
        $display("FAIL done_unexpected: got %0h expected none", a.ch_done);
      end else begin
        e = dq.pop_front();
        chk("done_onehot", a.ch_done, 64'(1) << e.ch);
        chk("done_hwdata", a.hwdata, e.data);
      end
    end
    if (a.ch_gnt != 0 && a.ch_gnt != prev_gnt) begin
      if (gq.size() == 0) begin
        checks++; errors++;
        $display("FAIL grant_unexpected: got %0h expected none", a.ch_gnt);
      end else begin
        g = gq.pop_front();
        chk("grant_onehot", a.ch_gnt, 64'(1) << g);
        chk("grant_owner", a.DMACActivedChannel, g);
        chk("grant_haddr", a.haddr, base(g));
        chk("grant_htrans", a.htrans, HTRANS_NONSEQ);
        seen_grant = 1;
      end
    end
    if (seen_grant && gq.size() != 0 && a.ch_gnt == 0) gaps++;
    if (!a.hready) chk("stall_no_done", a.ch_done, 0);
    if (!a.hready && !prev_hready) begin
      chk("stall_haddr", a.haddr, prev_haddr);
      chk("stall_gnt", a.ch_gnt, prev_gnt);
      chk("stall_data_ch", a.data_ch, prev_dch);
      chk("stall_hwdata", a.hwdata, prev_hwdata);
    end
    prev_gnt = a.ch_gnt;
    prev_hready = a.hready;
    prev_haddr = a.haddr;
    prev_hwdata = a.hwdata;
    prev_dch = a.data_ch;
  end

  always @(negedge hclk) begin
    exp_t e;
    int g;
    if (b.ch_done != 0) begin
      if (bdq.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_done_unexpected: got %0h expected none", b.ch_done);
      end else begin
        e = bdq.pop_front();
        chk("b_done_onehot", b.ch_done, 64'(1) << e.ch);
        chk("b_done_hwdata", b.hwdata, e.data);
      end
    end
    if (b.ch_gnt != 0 && b.ch_gnt != bprev) begin
      if (bgq.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_grant_unexpected: got %0h expected none", b.ch_gnt);
      end else begin
        g = bgq.pop_front();
        chk("b_grant_onehot", b.ch_gnt, 64'(1) << g);
        chk("b_grant_owner", b.DMACActivedChannel, g);
      end
    end
    bprev = b.ch_gnt;
  end

  initial begin
    int n;
    b.ch_req = '0; b.ch_last = '0; b.ch_hwrite = '0; b.ch_htrans = '0;
    b.ch_haddr = '0; b.ch_hwdata = '0; b.hready = 1'b1;
    do_reset();

    setch(0, 4, 1);
    gq.push_back(0);
    drive();
    repeat (12) cyc();
    @(negedge hclk);
    chk("t1_idle_gnt", a.ch_gnt, 0);
    chk("t1_idle_htrans", a.htrans, HTRANS_IDLE);
    drain("t1");

    do_reset();
    setch(0, 2, 2); setch(2, 2, 1); setch(5, 2, 1);
    gq = '{0, 2, 5, 0};
    drive();
    repeat (16) cyc();
    drain("t2");
    chk("t2_idle_gaps", gaps, 0);

    do_reset();
    setch(2, 3, 1);
    stall_arm = 1;
    gq.push_back(2);
    drive();
    repeat (14) cyc();
    drain("t3");

    do_reset();
    setch(1, 4, 1);
    drop_after[1] = 2;
    setch(3, 2, 1);
    gq = '{1, 3};
    drive();
    repeat (14) cyc();
    drain("t4");

    do_reset();
    setch(1, 4, 1);
    gq.push_back(1);
    drive();
    n = 0;
    while (sent[1] != 2 && n < 20) begin
      cyc();
      n++;
    end
    if (sent[1] != 2) begin
      checks++; errors++;
      $display("FAIL t5_timeout: got %0d beats expected 2", sent[1]);
    end
    hreset = 1'b1;
    eng_reset();
    dq.delete();
    setch(0, 1, 1);
    setch(1, 4, 1);
    gq = '{0, 1};
    drive();
    cyc();
    chk_reset_vals();
    hreset = 1'b0;
    repeat (14) cyc();
    drain("t5");

    b.ch_req = 3'b111; b.ch_last = 3'b111; b.ch_hwrite = 3'b111; b.ch_htrans = 6'b101010;
    b.ch_haddr = {base(2), base(1), base(0)};
    b.ch_hwdata = {bdata(2), bdata(1), bdata(0)};
    bgq = '{0, 1, 2, 0, 1, 2};
    for (int k = 0; k < 5; k++) bdq.push_back('{ch: k % 3, data: bdata(k % 3)});
    repeat (6) cyc();
    b.ch_req = '0;
    b.ch_htrans = '0;
    repeat (4) cyc();
    chk("t6_done_left", bdq.size(), 0);
    chk("t6_grant_left", bgq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dma_master_arb_mux.md
# dma_master_arb_mux

Parametrised AHB master-port arbiter and pipelined channel mux for the DMA controller. It replaces the fixed six-way combinational hwdata select with a round-robin arbiter over NUM_CH channels that owns the address phase. A one-stage data-phase tracker then routes hwdata and per-channel completion to the channel whose address phase was accepted. It sits between the channel engines and the single AHB master interface.

## Interface
- NUM_CH, 6, number of DMA channels (2..16)
- AW, 32, address width
- DW, 32, data width
- CHW, derived localparam $clog2(NUM_CH), channel index width

- hclk  in  1  bus clock, all logic rising-edge
- hreset  in  1  synchronous reset, active-high
- ch_req  in  NUM_CH  channel requests bus ownership
- ch_last  in  NUM_CH  channel's current address beat is its last
- ch_haddr  in  NUM_CH*AW  per-channel address, channel i at [i*AW +: AW]
- ch_htrans  in  NUM_CH*2  per-channel HTRANS
- ch_hwrite  in  NUM_CH  per-channel HWRITE
- ch_hwdata  in  NUM_CH*DW  per-channel write data
- hready  in  1  AHB HREADY
- haddr  out  AW  muxed address
- htrans  out  2  muxed HTRANS, IDLE (2'b00) when no owner
- hwrite  out  1  muxed HWRITE
- hwdata  out  DW  write data of data-phase owner
- ch_gnt  out  NUM_CH  one-hot address-phase grant
- ch_done  out  NUM_CH  one-hot, data phase of that channel completes this cycle
- DMACActivedChannel  out  CHW  address-phase owner index
- data_ch  out  CHW  data-phase owner index

## Operation
- FSM: IDLE (no owner, htrans=IDLE, ch_gnt=0) and OWN (owner = DMACActivedChannel).
- Round-robin: search starts at rr_ptr+1 modulo NUM_CH; first set ch_req bit wins; rr_ptr <= winner on grant.
- IDLE -> OWN: any ch_req set and hready=1; grant registered, visible next cycle.
- In OWN, haddr/htrans/hwrite = owner's ch_* signals; other channels see ch_gnt=0.
- Release when hready=1 and either (ch_last[owner]=1 and owner htrans is NONSEQ/SEQ) or ch_req[owner]=0.
- On release: if another (or the same) channel requests, the next winner per round-robin gets the grant the following cycle, staying in OWN (back-to-back handoff, no idle cycle); otherwise go to IDLE.
- Data phase: on every hready=1, d_valid <= (state==OWN and htrans is NONSEQ/SEQ), data_ch <= DMACActivedChannel.
- hwdata = ch_hwdata slice at data_ch (combinational from register); holds last value when d_valid=0.
- ch_done[data_ch] = hready & d_valid; all other bits 0.
- hready=0: all state, grant, data_ch and d_valid frozen.
- Simultaneous release and new requests: resolved in the same cycle; the releasing channel is eligible only after all others (rr order).

## Timing
- Reset values: state IDLE, rr_ptr NUM_CH-1 (channel 0 wins first), ch_gnt 0, DMACActivedChannel 0, data_ch 0, d_valid 0, htrans IDLE, haddr 0, hwrite 0, hwdata = ch_hwdata slice 0, ch_done 0.
- Request to first address phase on bus: 1 cycle (req sampled edge N, htrans valid from edge N).
- Address phase to ch_done: 1 hready-qualified cycle (standard AHB pipeline).
- hreset mid-transfer: in-flight data phase abandoned, ch_done not asserted; the bus sees htrans IDLE next cycle.
- Out-of-range channel indices are never produced; NUM_CH not a power of two wraps at NUM_CH-1 -> 0.

## Structure
- Shared package dma_pkg: HTRANS constants (IDLE, BUSY, NONSEQ, SEQ) and FSM state enum.
- One sub-module: dma_rr_arbiter (NUM_CH-wide rotate-priority encoder: req, ptr -> one-hot winner + index, any). The top level holds the FSM, muxes and data-phase register.

## Test plan
- Reset then ch_req=6'b000001, 4-beat write, ch_last on beat 4 -> ch_gnt=000001 one cycle later, 4 ch_done pulses on bit 0, hwdata = ch0 data each data phase, then IDLE.
- ch_req=6'b100101 held, each channel 2 beats -> grant order 0,2,5,0, back-to-back, no IDLE cycles between owners.
- hready low 3 cycles during owner 2's beat 2 -> haddr, ch_gnt, data_ch, hwdata stable; ch_done only after hready returns.
- Owner drops ch_req without ch_last while ch3 requests -> ch3 granted next cycle; owner's last accepted beat still gets ch_done.
- hreset during data phase of ch1 -> next cycle all outputs at reset values, no ch_done; channel 0 wins if requesting.
- NUM_CH=3, DW=64: requests on all three -> order 0,1,2,0; hwdata carries full 64-bit slice of each.
